// File: rtl/pt_rf_arbiter.sv
// pt_rf_arbiter: round-robin arbiter sharing one register-file port between
// NUM_REQ requesters. One access per cycle, responses return one cycle after
// the grant and are steered back to the issuing lane.
// Optional feature macro: PT_RF_ARB_LOCK_EN (grant locking to one requester).
module pt_rf_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int RF_ADDR_W = 32,
    parameter int DATA_W    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic                          o_idle,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]  i_req_address,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_wr_data,
    input  logic [NUM_REQ-1:0]            i_req_write,
    input  logic [NUM_REQ-1:0]            i_req_lock,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_W-1:0]             o_rsp_rd_data,
    output logic                          o_rsp_error,
    output logic [RF_ADDR_W-1:0]          o_rf_address,
    output logic [DATA_W-1:0]             o_rf_wr_data,
    output logic                          o_rf_write,
    output logic                          o_rf_enable,
    input  logic [DATA_W-1:0]             i_rf_rd_data,
    input  logic                          i_rf_error
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic               pending_q, pending_d;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand_sum;
    logic               found;
    logic               grant;
    logic               lock_q;
    logic               rsp_live;
    logic [NUM_REQ-1:0] lane_mask;
    logic [NUM_REQ-1:0] eligible;

`ifdef PT_RF_ARB_LOCK_EN
    logic               lock_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

    // While locked only the owning lane stays eligible for arbitration.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lock_mask
        assign lane_mask[gi] = !lock_q || (lock_idx_q == IDX_W'(gi));
    end

    // Each granted access decides whether the lock is held for the next one.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (grant) begin
            lock_d = i_req_lock[win_idx];
            if (i_req_lock[win_idx]) begin
                lock_idx_d = win_idx;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic lock_unused;

    assign lock_q      = 1'b0;
    assign lane_mask   = '1;
    assign lock_unused = ^i_req_lock;
`endif

    assign eligible = i_req_valid & lane_mask;

    // Round-robin search: first eligible lane at or after ptr_q, wrapping.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand_sum = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = int'(ptr_q) + k;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand_idx = IDX_W'(cand_sum);
            if (!found && eligible[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // Reset gates the grant combinationally so nothing leaks downstream.
    assign grant = found && i_rst_n;

    // Next-state for pointer and the one-deep response tracker.
    always_comb begin
        ptr_d      = ptr_q;
        pending_d  = grant;
        pend_idx_d = win_idx;
        if (grant) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Arbitration pointer and response tracker registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            pending_q  <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    // A response in flight is dropped if reset arrives before it is delivered.
    assign rsp_live = pending_q && i_rst_n;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane_out
        assign o_req_ready[gi] = grant && (win_idx == IDX_W'(gi));
        assign o_rsp_valid[gi] = rsp_live && (pend_idx_q == IDX_W'(gi));
    end

    // Downstream payload mux; outputs are zero when nothing is granted.
    always_comb begin
        o_rf_enable  = grant;
        o_rf_write   = 1'b0;
        o_rf_address = '0;
        o_rf_wr_data = '0;
        if (grant) begin
            o_rf_write   = i_req_write[win_idx];
            o_rf_address = i_req_address[win_idx*RF_ADDR_W +: RF_ADDR_W];
            o_rf_wr_data = i_req_wr_data[win_idx*DATA_W +: DATA_W];
        end
    end

    assign o_rsp_rd_data = rsp_live ? i_rf_rd_data : '0;
    assign o_rsp_error   = rsp_live ? i_rf_error : 1'b0;
    assign o_idle        = !(|i_req_valid) && !pending_q && !lock_q;

endmodule

// File: tb/tb_pt_rf_arbiter.sv
// Testbench for pt_rf_arbiter: a 2-lane and a 4-lane instance share the
// stimulus; each test selects which instance is checked. Expected responses
// are queued at grant time and popped when the response cycle arrives.
module tb_pt_rf_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_addr;
    logic [3:0][63:0]  req_wdata;
    logic [3:0]        req_write;
    logic [3:0]        req_lock;
    logic [63:0]       rf_rd_data;
    logic              rf_error;
    logic              use4;

    logic        idle2, idle4;
    logic [1:0]  ready2, rspv2;
    logic [3:0]  ready4, rspv4;
    logic [63:0] rspd2, rspd4, rfwd2, rfwd4;
    logic        rspe2, rspe4, rfw2, rfw4, rfen2, rfen4;
    logic [31:0] rfa2, rfa4;

    logic        obs_idle, obs_rsp_err, obs_en, obs_wr;
    logic [3:0]  obs_ready, obs_rsp_valid;
    logic [63:0] obs_rsp_data, obs_wdata;
    logic [31:0] obs_addr;

    typedef struct {
        int          lane;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    logic        rf_next_valid;
    logic [31:0] rf_next_addr;

    pt_rf_arbiter #(.NUM_REQ(2), .RF_ADDR_W(32), .DATA_W(64)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .o_idle(idle2),
        .i_req_valid(req_valid[1:0]), .o_req_ready(ready2),
        .i_req_address(req_addr[1:0]), .i_req_wr_data(req_wdata[1:0]),
        .i_req_write(req_write[1:0]), .i_req_lock(req_lock[1:0]),
        .o_rsp_valid(rspv2), .o_rsp_rd_data(rspd2), .o_rsp_error(rspe2),
        .o_rf_address(rfa2), .o_rf_wr_data(rfwd2), .o_rf_write(rfw2),
        .o_rf_enable(rfen2), .i_rf_rd_data(rf_rd_data), .i_rf_error(rf_error)
    );

    pt_rf_arbiter #(.NUM_REQ(4), .RF_ADDR_W(32), .DATA_W(64)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .o_idle(idle4),
        .i_req_valid(req_valid), .o_req_ready(ready4),
        .i_req_address(req_addr), .i_req_wr_data(req_wdata),
        .i_req_write(req_write), .i_req_lock(req_lock),
        .o_rsp_valid(rspv4), .o_rsp_rd_data(rspd4), .o_rsp_error(rspe4),
        .o_rf_address(rfa4), .o_rf_wr_data(rfwd4), .o_rf_write(rfw4),
        .o_rf_enable(rfen4), .i_rf_rd_data(rf_rd_data), .i_rf_error(rf_error)
    );

    assign obs_idle      = use4 ? idle4 : idle2;
    assign obs_ready     = use4 ? ready4 : {2'b00, ready2};
    assign obs_rsp_valid = use4 ? rspv4 : {2'b00, rspv2};
    assign obs_rsp_data  = use4 ? rspd4 : rspd2;
    assign obs_rsp_err   = use4 ? rspe4 : rspe2;
    assign obs_addr      = use4 ? rfa4 : rfa2;
    assign obs_wdata     = use4 ? rfwd4 : rfwd2;
    assign obs_wr        = use4 ? rfw4 : rfw2;
    assign obs_en        = use4 ? rfen4 : rfen2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file model: what the downstream returns for a given address.
    function automatic logic [63:0] rf_data(input logic [31:0] a);
        if (a == 32'h10) return 64'hDEAD;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic rf_err(input logic [31:0] a);
        if (a == 32'h10) return 1'b1;
        return a[3];
    endfunction

    task automatic set_lane(input int lane, input logic v, input logic [31:0] a,
                            input logic [63:0] d, input logic w, input logic l);
        req_valid[lane] = v;
        req_addr[lane]  = a;
        req_wdata[lane] = d;
        req_write[lane] = w;
        req_lock[lane]  = l;
    endtask

    // One clock cycle: check response, grant and payload, queue the expected
    // response, then drive the RF read data for the following cycle.
    task automatic step(input int exp_lane, input int exp_idle);
        exp_t        e;
        logic [3:0]  exp_ready;
        @(negedge clk);
        if (exp_idle >= 0) begin
            total++;
            if (obs_idle !== exp_idle[0]) begin
                bad++;
                $display("FAIL idle: got %b want %b", obs_idle, exp_idle[0]);
            end
        end
        total++;
        if (!rst_n) begin
            if (obs_rsp_valid !== 4'b0000) begin
                bad++;
                $display("FAIL rsp_in_reset: valid got %b want 0000", obs_rsp_valid);
            end
            sb_q.delete();
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (obs_rsp_valid !== (4'b0001 << e.lane) || obs_rsp_data !== e.data ||
                obs_rsp_err !== e.err) begin
                bad++;
                $display("FAIL rsp: got valid=%b data=%h err=%b want valid=%b data=%h err=%b",
                         obs_rsp_valid, obs_rsp_data, obs_rsp_err,
                         4'b0001 << e.lane, e.data, e.err);
            end else begin
                $display("rsp lane=%0d data=%h err=%b", e.lane, e.data, e.err);
            end
        end else if (obs_rsp_valid !== 4'b0000 || obs_rsp_data !== 64'h0 ||
                     obs_rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rsp_idle: got valid=%b data=%h err=%b want all zero",
                     obs_rsp_valid, obs_rsp_data, obs_rsp_err);
        end
        exp_ready = (exp_lane < 0) ? 4'b0000 : (4'b0001 << exp_lane);
        total++;
        if (obs_ready !== exp_ready || obs_en !== (exp_lane >= 0)) begin
            bad++;
            $display("FAIL grant: got ready=%b en=%b want ready=%b en=%b",
                     obs_ready, obs_en, exp_ready, exp_lane >= 0);
        end
        total++;
        if (exp_lane >= 0) begin
            if (obs_addr !== req_addr[exp_lane] || obs_wdata !== req_wdata[exp_lane] ||
                obs_wr !== req_write[exp_lane]) begin
                bad++;
                $display("FAIL payload: got a=%h d=%h w=%b want a=%h d=%h w=%b",
                         obs_addr, obs_wdata, obs_wr, req_addr[exp_lane],
                         req_wdata[exp_lane], req_write[exp_lane]);
            end
            e.lane = exp_lane;
            e.data = rf_data(req_addr[exp_lane]);
            e.err  = rf_err(req_addr[exp_lane]);
            sb_q.push_back(e);
            rf_next_valid = 1'b1;
            rf_next_addr  = req_addr[exp_lane];
        end else begin
            if (obs_addr !== 32'h0 || obs_wdata !== 64'h0 || obs_wr !== 1'b0) begin
                bad++;
                $display("FAIL payload_idle: got a=%h d=%h w=%b want zero",
                         obs_addr, obs_wdata, obs_wr);
            end
            rf_next_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        rf_rd_data = rf_next_valid ? rf_data(rf_next_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        rf_error   = rf_next_valid ? rf_err(rf_next_addr) : 1'b1;
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        step(-1, -1);
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        use4 = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 1'b1, 32'h100 * (i + 1), 64'h1111 * (i + 1), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(-1, 0);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        step(-1, 1);
    endtask

    task automatic test_fairness();
        use4 = 1'b0;
        req_valid = 4'b0011;
        req_write = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step(i % 2, 0);
            req_addr[i % 2]  = req_addr[i % 2] + 32'h8;
            req_wdata[i % 2] = req_wdata[i % 2] + 64'h1;
        end
        req_valid = 4'b0000;
        step(-1, 0);
        step(-1, 1);
    endtask

    task automatic test_routing();
        use4 = 1'b0;
        set_lane(1, 1'b1, 32'h10, 64'h0, 1'b0, 1'b0);
        req_valid[0] = 1'b0;
        step(1, 0);
        req_valid = 4'b0000;
        step(-1, 0);
        step(-1, 1);
    endtask

    task automatic test_reset_midop();
        use4 = 1'b0;
        do_reset();
        req_valid = 4'b0010;
        set_lane(1, 1'b1, 32'h48, 64'hABCD, 1'b1, 1'b0);
        step(1, 0);
        req_valid = 4'b0000;
        rst_n = 1'b0;
        step(-1, -1);
        rst_n = 1'b1;
        req_valid = 4'b0011;
        step(0, 0);
        step(1, 0);
        req_valid = 4'b0000;
        step(-1, 0);
    endtask

    task automatic test_wrap();
        use4 = 1'b1;
        do_reset();
        req_valid = 4'b0100;
        step(2, 0);
        req_valid = 4'b0101;
        step(0, 0);
        req_valid = 4'b0100;
        step(2, 0);
        req_valid = 4'b1111;
        step(3, 0);
        req_valid = 4'b0000;
        step(-1, 0);
        step(-1, 1);
    endtask

    task automatic test_lock();
        use4 = 1'b0;
        do_reset();
        set_lane(1, 1'b1, 32'h200, 64'h22, 1'b0, 1'b0);
        set_lane(0, 1'b1, 32'h300, 64'h31, 1'b1, 1'b1);
`ifdef PT_RF_ARB_LOCK_EN
        step(0, 0);
        set_lane(0, 1'b1, 32'h308, 64'h32, 1'b1, 1'b1);
        step(0, 0);
        set_lane(0, 1'b1, 32'h310, 64'h33, 1'b1, 1'b0);
        step(0, 0);
        req_valid[0] = 1'b0;
        step(1, 0);
`else
        step(0, 0);
        set_lane(0, 1'b1, 32'h308, 64'h32, 1'b1, 1'b1);
        step(1, 0);
        step(0, 0);
        set_lane(0, 1'b1, 32'h310, 64'h33, 1'b1, 1'b0);
        step(1, 0);
        step(0, 0);
        req_valid[0] = 1'b0;
        step(1, 0);
`endif
        req_valid = 4'b0000;
        step(-1, 0);
        step(-1, 1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        use4          = 1'b0;
        rst_n         = 1'b0;
        req_valid     = 4'b0000;
        req_addr      = '0;
        req_wdata     = '0;
        req_write     = 4'b0000;
        req_lock      = 4'b0000;
        rf_rd_data    = 64'hBAD0_BAD0_BAD0_BAD0;
        rf_error      = 1'b1;
        rf_next_valid = 1'b0;
        rf_next_addr  = '0;
        test_reset();
        test_fairness();
        test_routing();
        test_reset_midop();
        test_wrap();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
